// File: rtl/mips_multicycle_controller_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// The master side is the controller; the slave side is the datapath/IR/memory.
interface mips_multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       Opcode;
  logic [5:0]       Funct;
  logic             Zero;
  logic             MemReady;
  logic             PCWrite;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic [1:0]       RegDst;
  logic [1:0]       MemtoReg;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [2:0]       ALUOp;
  logic [1:0]       PCSource;
  logic [3:0]       State;
  logic             Illegal;
  logic [CNT_W-1:0] CycleCount;
  logic [CNT_W-1:0] InstrCount;

  modport master (
    input  Opcode, Funct, Zero, MemReady,
    output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, State, Illegal,
           CycleCount, InstrCount
  );

  modport slave (
    output Opcode, Funct, Zero, MemReady,
    input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg,
           RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, State, Illegal,
           CycleCount, InstrCount
  );
endinterface

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on MemReady, and keeps cycle and retired-instruction counters.
module mips_multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  mips_multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    I_EXEC    = 4'd10,
    I_WB      = 4'd11,
    JAL       = 4'd12,
    JR        = 4'd13,
    ILLEGAL   = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_AND   = 3'b100;
  localparam logic [2:0] ALU_LUI   = 3'b101;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  state_t           state, next_state;
  ctrl_t            ctrl;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;
  logic             illegal_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= FETCH;
      cycle_cnt <= '0;
      instr_cnt <= '0;
      illegal_q <= 1'b0;
    end else begin
      state <= next_state;
      if (state != ILLEGAL)
        cycle_cnt <= cycle_cnt + 1'b1;
      // Retirement is the edge back into FETCH; a FETCH stall is not a retire.
      if (next_state == FETCH && state != FETCH)
        instr_cnt <= instr_cnt + 1'b1;
      if (next_state == ILLEGAL)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    ctrl       = '0;
    next_state = state;
    unique case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        ctrl.ir_write  = bus.MemReady;
        ctrl.pc_write  = bus.MemReady;
        if (bus.MemReady) next_state = DECODE;
      end
      DECODE: begin
        ctrl.alu_src_b = 2'b11;
        unique case (bus.Opcode)
          OP_RTYPE:                         next_state = (bus.Funct == FN_JR) ? JR : R_EXEC;
          OP_LW, OP_SW:                     next_state = MEM_ADDR;
          OP_BEQ, OP_BNE:                   next_state = BRANCH;
          OP_J:                             next_state = JUMP;
          OP_JAL:                           next_state = JAL;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: next_state = I_EXEC;
          default:                          next_state = ILLEGAL;
        endcase
      end
      MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        next_state     = (bus.Opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (bus.MemReady) next_state = MEM_WB;
      end
      MEM_WB: begin
        ctrl.mem_to_reg = 2'b01;
        ctrl.reg_write  = 1'b1;
        next_state      = FETCH;
      end
      MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (bus.MemReady) next_state = FETCH;
      end
      R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
        next_state     = R_WB;
      end
      R_WB: begin
        ctrl.reg_dst   = 2'b01;
        ctrl.reg_write = 1'b1;
        next_state     = FETCH;
      end
      BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_source = 2'b01;
        ctrl.pc_write  = (bus.Opcode == OP_BNE) ? ~bus.Zero : bus.Zero;
        next_state     = FETCH;
      end
      JUMP: begin
        ctrl.pc_source = 2'b10;
        ctrl.pc_write  = 1'b1;
        next_state     = FETCH;
      end
      I_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        unique case (bus.Opcode)
          OP_ANDI: ctrl.alu_op = ALU_AND;
          OP_ORI:  ctrl.alu_op = ALU_OR;
          OP_LUI:  ctrl.alu_op = ALU_LUI;
          default: ctrl.alu_op = ALU_ADD;
        endcase
        next_state = I_WB;
      end
      I_WB: begin
        ctrl.reg_write = 1'b1;
        next_state     = FETCH;
      end
      JAL: begin
        ctrl.pc_source  = 2'b10;
        ctrl.pc_write   = 1'b1;
        ctrl.reg_dst    = 2'b10;
        ctrl.mem_to_reg = 2'b10;
        ctrl.reg_write  = 1'b1;
        next_state      = FETCH;
      end
      JR: begin
        ctrl.pc_source = 2'b11;
        ctrl.pc_write  = 1'b1;
        next_state     = FETCH;
      end
      ILLEGAL: next_state = ILLEGAL;
      default: next_state = FETCH;
    endcase
  end

  // Strobes are gated by reset so an abandoned instruction commits nothing.
  assign bus.PCWrite    = ctrl.pc_write  & reset;
  assign bus.MemRead    = ctrl.mem_read  & reset;
  assign bus.MemWrite   = ctrl.mem_write & reset;
  assign bus.IRWrite    = ctrl.ir_write  & reset;
  assign bus.RegWrite   = ctrl.reg_write & reset;
  assign bus.IorD       = ctrl.iord;
  assign bus.RegDst     = ctrl.reg_dst;
  assign bus.MemtoReg   = ctrl.mem_to_reg;
  assign bus.ALUSrcA    = ctrl.alu_src_a;
  assign bus.ALUSrcB    = ctrl.alu_src_b;
  assign bus.ALUOp      = ctrl.alu_op;
  assign bus.PCSource   = ctrl.pc_source;
  assign bus.State      = state;
  assign bus.Illegal    = illegal_q;
  assign bus.CycleCount = cycle_cnt;
  assign bus.InstrCount = instr_cnt;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Bench for the multicycle MIPS controller: per-instruction state-path model
// plus control-word table, checked every cycle on a 32-bit and a 4-bit counter build.
module tb_mips_multicycle_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_multicycle_controller_if #(.CNT_W(32)) b32 ();
  mips_multicycle_controller_if #(.CNT_W(4))  b4 ();

  mips_multicycle_controller #(.CNT_W(32)) dut32 (.clk(clk), .reset(reset), .bus(b32));
  mips_multicycle_controller #(.CNT_W(4))  dut4  (.clk(clk), .reset(reset), .bus(b4));

  typedef struct packed {
    logic       pcw;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic [1:0] regdst;
    logic [1:0] m2r;
    logic       rw;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
  } ctl_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_cyc, m_instr;
  logic        m_ill;
  int          prev_s, exp_s;
  logic        prev_rst;
  logic        chk_on = 1'b0;
  logic        alt = 1'b0;
  logic [5:0]  cur_op, cur_fn;
  logic        cur_z, cur_rdy;
  logic [31:0] c0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Control word each state must present, straight from the state table.
  function automatic ctl_t exp_ctl(input int s, input logic [5:0] op, input logic z,
                                   input logic rdy, input logic rst);
    ctl_t c = '0;
    case (s)
      0:  begin c.mr = 1; c.srcb = 2'b01; c.irw = rdy; c.pcw = rdy; end
      1:  c.srcb = 2'b11;
      2:  begin c.srca = 1; c.srcb = 2'b10; end
      3:  begin c.mr = 1; c.iord = 1; end
      4:  begin c.m2r = 2'b01; c.rw = 1; end
      5:  begin c.mw = 1; c.iord = 1; end
      6:  begin c.srca = 1; c.aluop = 3'b010; end
      7:  begin c.regdst = 2'b01; c.rw = 1; end
      8:  begin c.srca = 1; c.aluop = 3'b001; c.pcsrc = 2'b01;
                c.pcw = (op == 6'b000100) ? z : ~z; end
      9:  begin c.pcsrc = 2'b10; c.pcw = 1; end
      10: begin c.srca = 1; c.srcb = 2'b10;
                c.aluop = (op == 6'b001100) ? 3'b100 : (op == 6'b001101) ? 3'b011 :
                          (op == 6'b001111) ? 3'b101 : 3'b000; end
      11: c.rw = 1;
      12: begin c.pcsrc = 2'b10; c.pcw = 1; c.regdst = 2'b10; c.m2r = 2'b10; c.rw = 1; end
      13: begin c.pcsrc = 2'b11; c.pcw = 1; end
      default: ;
    endcase
    if (!rst) begin c.pcw = 0; c.mr = 0; c.mw = 0; c.irw = 0; c.rw = 0; end
    return c;
  endfunction

  always @(negedge clk) begin : cmp
    ctl_t e, a32, a4;
    if (chk_on) begin
      e   = exp_ctl(exp_s, cur_op, cur_z, cur_rdy, reset);
      a32 = {b32.PCWrite, b32.IorD, b32.MemRead, b32.MemWrite, b32.IRWrite, b32.RegDst,
             b32.MemtoReg, b32.RegWrite, b32.ALUSrcA, b32.ALUSrcB, b32.ALUOp, b32.PCSource};
      a4  = {b4.PCWrite, b4.IorD, b4.MemRead, b4.MemWrite, b4.IRWrite, b4.RegDst,
             b4.MemtoReg, b4.RegWrite, b4.ALUSrcA, b4.ALUSrcB, b4.ALUOp, b4.PCSource};
      check("ctrl32",    64'(a32), 64'(e));
      check("ctrl4",     64'(a4), 64'(e));
      check("state32",   64'(b32.State), 64'(exp_s));
      check("state4",    64'(b4.State), 64'(exp_s));
      check("illegal32", 64'(b32.Illegal), 64'(m_ill));
      check("illegal4",  64'(b4.Illegal), 64'(m_ill));
      check("cycles32",  64'(b32.CycleCount), 64'(m_cyc));
      check("instrs32",  64'(b32.InstrCount), 64'(m_instr));
      check("cycles4",   64'(b4.CycleCount), 64'(m_cyc[3:0]));
      check("instrs4",   64'(b4.InstrCount), 64'(m_instr[3:0]));
    end
  end

  task automatic set_ir(input logic [5:0] op, input logic [5:0] fn, input logic z);
    cur_op = op; cur_fn = fn; cur_z = z;
    b32.Opcode = op; b32.Funct = fn; b32.Zero = z;
    b4.Opcode  = op; b4.Funct  = fn; b4.Zero  = z;
  endtask

  // One clock in state s: advance the counter model from the previous cycle, drive, compare.
  task automatic step(input int s, input logic r, input logic rd);
    if (!prev_rst) begin
      m_cyc = '0; m_instr = '0; m_ill = 1'b0;
    end else begin
      if (prev_s != 14) m_cyc = m_cyc + 1;
      if (s == 0 && prev_s != 0) m_instr = m_instr + 1;
      if (s == 14) m_ill = 1'b1;
    end
    reset = r; cur_rdy = rd; b32.MemReady = rd; b4.MemReady = rd;
    exp_s = s; chk_on = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    prev_s = s; prev_rst = r; alt = ~alt;
  endtask

  // MemReady outside memory states toggles to show it is ignored.
  task automatic stepx(input int s);
    step(s, 1'b1, alt);
  endtask

  // State path of a whole instruction, with fw FETCH and mw memory wait cycles.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw);
    set_ir(op, fn, z);
    for (int i = 0; i <= fw; i++) step(0, 1'b1, i == fw);
    stepx(1);
    case (op)
      6'b000000: if (fn == 6'b001000) stepx(13); else begin stepx(6); stepx(7); end
      6'b100011: begin
        stepx(2);
        for (int i = 0; i <= mw; i++) step(3, 1'b1, i == mw);
        stepx(4);
      end
      6'b101011: begin
        stepx(2);
        for (int i = 0; i <= mw; i++) step(5, 1'b1, i == mw);
      end
      6'b000100, 6'b000101: stepx(8);
      6'b000010: stepx(9);
      6'b000011: stepx(12);
      6'b001000, 6'b001100, 6'b001101, 6'b001111: begin stepx(10); stepx(11); end
      default: begin stepx(14); stepx(14); stepx(14); end
    endcase
  endtask

  initial begin
    reset = 1'b0;
    set_ir(6'd0, 6'd0, 1'b0);
    b32.MemReady = 1'b0; b4.MemReady = 1'b0;
    m_cyc = '0; m_instr = '0; m_ill = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    prev_s = 0; prev_rst = 1'b0;

    // Reset state, strobes held off.
    step(0, 1'b0, 1'b1);

    // add, MemReady high throughout.
    run_instr(6'b000000, 6'b100000, 1'b0, 0, 0);
    check("pin_instr_after_add", 64'(b32.InstrCount), 64'd1);
    check("pin_cycles_after_add", 64'(b32.CycleCount), 64'd4);

    // lw with three MEM_READ wait cycles takes 8 cycles.
    c0 = b32.CycleCount;
    run_instr(6'b100011, 6'd0, 1'b0, 0, 3);
    check("pin_lw_cycles", 64'(b32.CycleCount - c0), 64'd8);
    check("pin_instr_after_lw", 64'(b32.InstrCount), 64'd2);

    // Branches taken / not taken, jumps, immediates, stores, fetch stalls.
    run_instr(6'b000100, 6'd0, 1'b1, 0, 0);
    run_instr(6'b000100, 6'd0, 1'b0, 0, 0);
    run_instr(6'b000101, 6'd0, 1'b1, 0, 0);
    run_instr(6'b000101, 6'd0, 1'b0, 1, 0);
    run_instr(6'b000011, 6'd0, 1'b0, 0, 0);
    run_instr(6'b000010, 6'd0, 1'b0, 2, 0);
    run_instr(6'b000000, 6'b001000, 1'b0, 0, 0);
    run_instr(6'b001000, 6'd0, 1'b0, 0, 0);
    run_instr(6'b001100, 6'd0, 1'b0, 0, 0);
    run_instr(6'b001101, 6'd0, 1'b0, 0, 0);
    run_instr(6'b001111, 6'd0, 1'b0, 0, 0);
    run_instr(6'b101011, 6'd0, 1'b0, 1, 2);
    check("pin_instr_mid", 64'(b32.InstrCount), 64'd14);

    // Illegal opcode: terminal, sticky flag, cycle counter frozen after DECODE.
    c0 = b32.CycleCount;
    run_instr(6'b111111, 6'd0, 1'b0, 0, 0);
    check("pin_illegal_flag", 64'(b32.Illegal), 64'd1);
    check("pin_illegal_frozen", 64'(b32.CycleCount - c0), 64'd2);
    step(14, 1'b0, 1'b1);
    check("pin_rst_state", 64'(b32.State), 64'd0);
    check("pin_rst_illegal", 64'(b32.Illegal), 64'd0);
    check("pin_rst_cycles", 64'(b32.CycleCount), 64'd0);
    check("pin_rst_instrs", 64'(b32.InstrCount), 64'd0);

    // Reset during a stalled store abandons it.
    set_ir(6'b101011, 6'd0, 1'b0);
    step(0, 1'b1, 1'b1);
    stepx(1);
    stepx(2);
    step(5, 1'b1, 1'b0);
    step(5, 1'b0, 1'b0);
    check("pin_abandon_state", 64'(b32.State), 64'd0);
    check("pin_abandon_instrs", 64'(b32.InstrCount), 64'd0);

    // Sixteen retirements wrap the 4-bit counter.
    for (int i = 0; i < 16; i++) run_instr(6'b000010, 6'd0, 1'b0, 0, 0);
    check("pin_wrap_instr4", 64'(b4.InstrCount), 64'd0);
    check("pin_wrap_instr32", 64'(b32.InstrCount), 64'd16);

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
